bank_registers_mp: RTL and testbench

- Parametrised successor of the MIPS register bank: N_RD_PORTS synchronous read ports, one write port, hardwired-zero register, optional write-through forwarding.
- Sits in the ID stage; WB drives the write port.
- Adds a backpressured register-dump channel that streams the whole bank to the FPGA debug unit.

---
 rtl/bank_registers_pkg.sv | 17 +
 rtl/bank_registers_dump_ctrl.sv | 75 +++++++
 rtl/bank_registers_mp.sv | 105 ++++++++++
 tb/tb_bank_registers_mp.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_registers_pkg.sv
// Shared types and constants for the multi-port register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bank_registers_pkg;

    localparam int NB_REG_DEF  = 5;
    localparam int NB_DATA_DEF = 32;

    // Index of the register that may be hardwired to zero
    localparam int ZERO_ADDR = 0;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_BUSY = 1'b1
    } dump_state_t;

endpackage

// File: rtl/bank_registers_dump_ctrl.sv
// Dump sequencer: walks index 0..N_REGISTER-1, one beat per accepted handshake.
// Latency: first beat valid the cycle after dump_start_i; done pulses the cycle after the last transfer.
// Backpressure: dump_ready_i=0 holds the current index; dump_start_i is ignored while busy.
module bank_registers_dump_ctrl
    import bank_registers_pkg::*;
#(
    parameter int NB_REG     = NB_REG_DEF,
    parameter int N_REGISTER = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              dump_start_i,
    input  logic              dump_ready_i,
    output logic              dump_valid_o,
    output logic [NB_REG-1:0] dump_addr_o,
    output logic              dump_last_o,
    output logic              dump_done_o
);

    localparam logic [NB_REG-1:0] LAST_IDX = NB_REG'(N_REGISTER - 1);

    dump_state_t       state_q;
    logic [NB_REG-1:0] idx_q;
    logic              valid_q;
    logic              last_q;
    logic              done_q;

    // Dump FSM with registered valid/last/done; last is precomputed as idx advances
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DUMP_IDLE: begin
                    if (dump_start_i) begin
                        state_q <= DUMP_BUSY;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (LAST_IDX == '0);
                    end
                end
                DUMP_BUSY: begin
                    if (dump_ready_i) begin
                        if (last_q) begin
                            state_q <= DUMP_IDLE;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + NB_REG'(1);
                            last_q <= ((idx_q + NB_REG'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= DUMP_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid_o = valid_q;
    assign dump_addr_o  = idx_q;
    assign dump_last_o  = last_q;
    assign dump_done_o  = done_q;

endmodule

// File: rtl/bank_registers_mp.sv
// Multi-port register bank: N_RD_PORTS registered reads, one write, optional hardwired r0, debug dump stream.
// Latency: reads 1 cycle; dump data combinational from the array at the current dump index.
// Backpressure: dump channel is valid/ready; reads and writes are never stalled by dumping.
// Optional: define BANK_REGISTERS_BYPASS_EN for write-through forwarding into same-edge reads.
module bank_registers_mp
    import bank_registers_pkg::*;
#(
    parameter int NB_REG        = NB_REG_DEF,
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int N_REGISTER    = 32,
    parameter int N_RD_PORTS    = 2,
    parameter int HARDWIRE_ZERO = 1
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [N_RD_PORTS-1:0]         rd_en_i,
    input  logic [N_RD_PORTS*NB_REG-1:0]  rd_addr_i,
    output logic [N_RD_PORTS*NB_DATA-1:0] rd_data_o,
    input  logic                          wr_en_i,
    input  logic [NB_REG-1:0]             wr_addr_i,
    input  logic [NB_DATA-1:0]            wr_data_i,
    input  logic                          dump_start_i,
    input  logic                          dump_ready_i,
    output logic                          dump_valid_o,
    output logic [NB_REG-1:0]             dump_addr_o,
    output logic [NB_DATA-1:0]            dump_data_o,
    output logic                          dump_last_o,
    output logic                          dump_done_o
);

    logic [NB_DATA-1:0]            regs_q [N_REGISTER];
    logic [N_RD_PORTS*NB_DATA-1:0] rd_data_q;
    logic [N_RD_PORTS*NB_DATA-1:0] rd_data_d;
    logic                          wr_ok;
    logic [NB_REG-1:0]             dump_idx;

    // Stored value as seen by readers: out-of-range and hardwired r0 read as zero
    function automatic logic [NB_DATA-1:0] lookup(input logic [NB_REG-1:0] addr);
        if (int'(addr) >= N_REGISTER)
            return '0;
        if ((HARDWIRE_ZERO != 0) && (int'(addr) == ZERO_ADDR))
            return '0;
        return regs_q[addr];
    endfunction

    // Write is accepted only for in-range addresses, and never for a hardwired r0
    always_comb begin
        wr_ok = wr_en_i && (int'(wr_addr_i) < N_REGISTER);
        if ((HARDWIRE_ZERO != 0) && (int'(wr_addr_i) == ZERO_ADDR))
            wr_ok = 1'b0;
    end

    // Register array: synchronous clear of every entry, single write port
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N_REGISTER; i++)
                regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Per-port next read value; disabled ports hold their last result
    always_comb begin
        rd_data_d = rd_data_q;
        for (int k = 0; k < N_RD_PORTS; k++) begin
            if (rd_en_i[k]) begin
                rd_data_d[k*NB_DATA +: NB_DATA] = lookup(rd_addr_i[k*NB_REG +: NB_REG]);
`ifdef BANK_REGISTERS_BYPASS_EN
                if (wr_ok && (wr_addr_i == rd_addr_i[k*NB_REG +: NB_REG]))
                    rd_data_d[k*NB_DATA +: NB_DATA] = wr_data_i;
`endif
            end
        end
    end

    // Registered read outputs
    always_ff @(posedge clock_i) begin
        if (!reset_i)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

    bank_registers_dump_ctrl #(
        .NB_REG     (NB_REG),
        .N_REGISTER (N_REGISTER)
    ) u_dump_ctrl (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .dump_start_i (dump_start_i),
        .dump_ready_i (dump_ready_i),
        .dump_valid_o (dump_valid_o),
        .dump_addr_o  (dump_idx),
        .dump_last_o  (dump_last_o),
        .dump_done_o  (dump_done_o)
    );

    assign dump_addr_o = dump_idx;
    // Dump data tracks the array directly, so a write to the held index shows up the next cycle
    assign dump_data_o = lookup(dump_idx);

endmodule

// File: tb/tb_bank_registers_mp.sv
// Self-checking bench for bank_registers_mp with default parameters.
// Latency: n/a.
// Backpressure: exercises dump ready toggling and holding.
module tb_bank_registers_mp;

    localparam int NREG = 32;
`ifdef BANK_REGISTERS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rd_en;
    logic [4:0]  raddr [2];
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        dstart;
    logic        dready;
    logic        dvalid;
    logic [4:0]  daddr;
    logic [31:0] ddata;
    logic        dlast;
    logic        ddone;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem    [NREG];
    logic [31:0] exp_rd [2];

    always #5 clk = ~clk;

    assign rd_addr = {raddr[1], raddr[0]};

    bank_registers_mp dut (
        .clock_i      (clk),
        .reset_i      (reset_n),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .wr_en_i      (we),
        .wr_addr_i    (waddr),
        .wr_data_i    (wdata),
        .dump_start_i (dstart),
        .dump_ready_i (dready),
        .dump_valid_o (dvalid),
        .dump_addr_o  (daddr),
        .dump_data_o  (ddata),
        .dump_last_o  (dlast),
        .dump_done_o  (ddone)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference view of the bank: r0 and out-of-range addresses read as zero
    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= NREG)
            return 32'h0;
        return mem[a];
    endfunction

    // Advance one clock, updating the reference model from the inputs presented at that edge
    task automatic tick();
        logic [31:0] nx [2];
        bit wok;
        wok = we && (waddr != 5'd0) && (int'(waddr) < NREG);
        for (int k = 0; k < 2; k++) begin
            nx[k] = exp_rd[k];
            if (!reset_n)
                nx[k] = 32'h0;
            else if (rd_en[k]) begin
                nx[k] = mread(raddr[k]);
                if (BYP && wok && waddr == raddr[k])
                    nx[k] = wdata;
            end
        end
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++)
                mem[i] = 32'h0;
        end else if (wok) begin
            mem[waddr] = wdata;
        end
        @(posedge clk);
        #1;
        exp_rd[0] = nx[0];
        exp_rd[1] = nx[1];
    endtask

    task automatic chk_rd(input string tag);
        chk({tag, "_p0"}, rd_data[31:0], exp_rd[0]);
        chk({tag, "_p1"}, rd_data[63:32], exp_rd[1]);
    endtask

    // Run one complete dump, checking every beat against the model
    task automatic run_dump(input bit toggle, input string tag);
        int beat;
        int cyc;
        bit rdy;
        bit x;
        beat = 0;
        cyc  = 0;
        rdy  = 1'b1;
        dstart = 1'b1;
        tick();
        dstart = 1'b0;
        while (beat < NREG && cyc < 300) begin
            dready = rdy;
            if (toggle)
                rdy = !rdy;
            chk({tag, "_valid"}, {31'b0, dvalid}, 32'd1);
            chk({tag, "_addr"}, {27'b0, daddr}, beat);
            chk({tag, "_data"}, ddata, mread(beat[4:0]));
            chk({tag, "_last"}, {31'b0, dlast}, (beat == NREG - 1) ? 32'd1 : 32'd0);
            chk({tag, "_done_early"}, {31'b0, ddone}, 32'd0);
            x = dready;
            tick();
            if (x)
                beat++;
            cyc++;
        end
        if (beat < NREG) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", tag, beat, NREG);
        end
        dready = 1'b0;
        chk({tag, "_done"}, {31'b0, ddone}, 32'd1);
        chk({tag, "_idle_valid"}, {31'b0, dvalid}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, ddone}, 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        rd_en    = 2'b00;
        raddr[0] = 5'd0;
        raddr[1] = 5'd0;
        we       = 1'b0;
        waddr    = 5'd0;
        wdata    = 32'h0;
        dstart   = 1'b0;
        dready   = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        for (int i = 0; i < NREG; i++)
            mem[i] = 32'h0;

        tick();
        tick();
        reset_n = 1'b1;
        chk_rd("init");
        chk("init_valid", {31'b0, dvalid}, 32'd0);
        chk("init_addr", {27'b0, daddr}, 32'd0);

        // Directed vectors: write/read latency, same-edge read, r0 drop, per-port hold
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd7, 32'h1234, 2'b11, 5'd7, 5'd7,
                   BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0};
        tbl[3] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd7, 32'h1234, 32'h1234};
        tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 2'b01, 5'd0, 5'd5, 32'h0, 32'h1234};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
        tbl[6] = '{1'b1, 5'd5, 32'h55, 2'b10, 5'd0, 5'd5,
                   32'h0, BYP ? 32'h55 : 32'hDEADBEEF};
        tbl[7] = '{1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 32'h55, 32'h1234};
        for (int v = 0; v < 8; v++) begin
            we       = tbl[v].we;
            waddr    = tbl[v].wa;
            wdata    = tbl[v].wd;
            rd_en    = tbl[v].ren;
            raddr[0] = tbl[v].ra0;
            raddr[1] = tbl[v].ra1;
            tick();
            chk($sformatf("vec%0d_p0", v), rd_data[31:0], tbl[v].e0);
            chk($sformatf("vec%0d_p1", v), rd_data[63:32], tbl[v].e1);
        end
        we = 1'b0;

        // Random traffic on a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            we       = 1'($urandom_range(0, 1));
            waddr    = 5'($urandom_range(0, 7));
            wdata    = $urandom();
            rd_en    = 2'($urandom_range(0, 3));
            raddr[0] = 5'($urandom_range(0, 7));
            raddr[1] = 5'($urandom_range(0, 7));
            tick();
            chk_rd("rand");
        end

        // Reset after writes: outputs clear, concurrent write and dump start are discarded
        we       = 1'b1;
        waddr    = 5'd3;
        wdata    = 32'hABCD0003;
        rd_en    = 2'b11;
        dstart   = 1'b1;
        reset_n  = 1'b0;
        tick();
        chk_rd("rst");
        chk("rst_valid", {31'b0, dvalid}, 32'd0);
        chk("rst_last", {31'b0, dlast}, 32'd0);
        chk("rst_done", {31'b0, ddone}, 32'd0);
        chk("rst_addr", {27'b0, daddr}, 32'd0);
        reset_n = 1'b1;
        we      = 1'b0;
        dstart  = 1'b0;
        tick();
        chk("rst_start_dropped", {31'b0, dvalid}, 32'd0);
        for (int i = 0; i < NREG / 2; i++) begin
            raddr[0] = 5'(2 * i);
            raddr[1] = 5'(2 * i + 1);
            tick();
            chk_rd("rst_clear");
        end

        // Fill r[i]=i+100 (r0 write is dropped), then dump with ready toggling
        rd_en = 2'b00;
        for (int i = 0; i < NREG; i++) begin
            we    = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i + 100);
            tick();
        end
        we       = 1'b0;
        rd_en    = 2'b11;
        raddr[0] = 5'd0;
        raddr[1] = 5'd31;
        tick();
        chk("r0_hardwired", rd_data[31:0], 32'h0);
        chk("r31_fill", rd_data[63:32], 32'd131);
        rd_en = 2'b00;
        run_dump(1'b1, "dump_tog");

        // Dump with a held beat that is overwritten, then reset at beat 10
        dstart = 1'b1;
        tick();
        dstart = 1'b0;
        chk("d2_first_addr", {27'b0, daddr}, 32'd0);
        chk("d2_first_valid", {31'b0, dvalid}, 32'd1);
        dready = 1'b1;
        repeat (3) tick();
        chk("d2_addr3", {27'b0, daddr}, 32'd3);
        dready = 1'b0;
        we     = 1'b1;
        waddr  = 5'd3;
        wdata  = 32'hCAFE0003;
        tick();
        we = 1'b0;
        chk("hold_addr", {27'b0, daddr}, 32'd3);
        chk("hold_data", ddata, 32'hCAFE0003);
        chk("hold_valid", {31'b0, dvalid}, 32'd1);
        dready = 1'b1;
        repeat (7) tick();
        chk("d2_addr10", {27'b0, daddr}, 32'd10);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("abort_valid", {31'b0, dvalid}, 32'd0);
        chk("abort_addr", {27'b0, daddr}, 32'd0);
        chk("abort_done", {31'b0, ddone}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", {31'b0, ddone}, 32'd0);
            chk("abort_stay_idle", {31'b0, dvalid}, 32'd0);
        end
        we    = 1'b1;
        waddr = 5'd1;
        wdata = 32'hA5;
        tick();
        we    = 1'b0;
        run_dump(1'b0, "dump_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
